// File: rtl/muxn_arb_pkg.sv
// Shared constants and types for the muxn_arb registered channel selector.
package muxn_arb_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NCH   = 4;

  // Output pipeline register occupancy.
  typedef enum logic {
    StEmpty,
    StFull
  } out_state_e;

endpackage

// File: rtl/muxn_arb_if.sv
// Channel/handshake bundle for muxn_arb; master is the surrounding datapath.
interface muxn_arb_if
  import muxn_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCH   = DEF_NCH
) ();

  localparam int unsigned SELW = $clog2(NCH);

  logic [SELW-1:0]      sel;
  logic                 mode;
  logic [NCH*WIDTH-1:0] d_in;
  logic [NCH-1:0]       valid_in;
  logic [NCH-1:0]       ready_in;
  logic [WIDTH-1:0]     d_out;
  logic [SELW-1:0]      gnt_out;
  logic                 valid_out;
  logic                 ready_out;

  modport master (
    output sel, mode, d_in, valid_in, ready_out,
    input  ready_in, d_out, gnt_out, valid_out
  );

  modport slave (
    input  sel, mode, d_in, valid_in, ready_out,
    output ready_in, d_out, gnt_out, valid_out
  );

endinterface

// File: rtl/muxn_arb_rr_pick.sv
// Round-robin picker: first requesting channel after ptr, wrapping modulo NCH.
module muxn_arb_rr_pick #(
  parameter int unsigned NCH  = 4,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] gnt_o,
  output logic            any_o
);

  logic [SELW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx   = '0;
    found = 1'b0;
    // Scan ptr+1 .. ptr+NCH so the last winner has lowest priority.
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = SELW'((32'(ptr_i) + i) % NCH);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        gnt_o = idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/muxn_arb.sv
// N-channel registered selector with valid/ready handshakes on both sides.
// Round-robin arbitration (MODE input, ptr register) is built only with MUXN_ARB_RR_EN.
module muxn_arb
  import muxn_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCH   = DEF_NCH
) (
  input logic       clk,
  input logic       rst_n,
  muxn_arb_if.slave bus
);

  localparam int unsigned SELW = $clog2(NCH);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] d_q, d_sel;
  logic [SELW-1:0]  gnt_q, chosen;
  logic [NCH-1:0]   ready_in;
  logic             sel_ok, cand, load, xfer_in, rr_active;

  // Codes at or above NCH exist when NCH is not a power of two; they never grant.
  assign sel_ok = 32'(bus.sel) < NCH;
  assign load   = (state_q == StEmpty) || bus.ready_out;

`ifdef MUXN_ARB_RR_EN
  logic [SELW-1:0] ptr_q, rr_gnt;
  logic            rr_any;

  assign rr_active = (bus.mode == MODE_RR);

  muxn_arb_rr_pick #(
    .NCH (NCH)
  ) u_rr_pick (
    .req_i (bus.valid_in),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .any_o (rr_any)
  );

  // ptr resets to NCH-1 so channel 0 wins the first round-robin pick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SELW'(NCH - 1);
    end else if (xfer_in && rr_active) begin
      ptr_q <= chosen;
    end
  end
`else
  logic unused_mode;

  assign rr_active   = 1'b0;
  assign unused_mode = bus.mode;
`endif

  always_comb begin
    chosen = bus.sel;
    cand   = sel_ok && bus.valid_in[bus.sel];
`ifdef MUXN_ARB_RR_EN
    if (rr_active) begin
      chosen = rr_gnt;
      cand   = rr_any;
    end
`endif
  end

  // A candidate is always valid, so ready and valid coincide on the chosen channel.
  assign xfer_in = load && cand;

  always_comb begin
    ready_in = '0;
    if (xfer_in) begin
      ready_in[chosen] = 1'b1;
    end
  end

  always_comb begin
    d_sel = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(chosen) == k) begin
        d_sel = bus.d_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (xfer_in) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (!xfer_in && bus.ready_out) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      d_q     <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer_in) begin
        d_q   <= d_sel;
        gnt_q <= chosen;
      end
    end
  end

  assign bus.ready_in  = ready_in;
  assign bus.d_out     = d_q;
  assign bus.gnt_out   = gnt_q;
  assign bus.valid_out = (state_q == StFull);

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ready_in));

  a_stall_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.valid_out && !bus.ready_out) |=> (bus.valid_out && $stable(bus.d_out)
                                            && $stable(bus.gnt_out)));

  a_bad_sel : assert property (@(posedge clk) disable iff (!rst_n)
    (!rr_active && !sel_ok) |-> (ready_in == '0));

endmodule
